// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Shared types and constants for the RV32I pipeline hazard logic.
//   Holds the hazard FSM state encoding, the EX-stage forward-select codes,
//   the shadow scoreboard entry type and small helpers used to query entries.
//   No ports: this file only declares types, constants and functions.
// -----------------------------------------------------------------------------
package core_pkg;

  // Register-address width tracked by the shadow scoreboard entries.
  localparam int CORE_REG_W = 5;

  // Hazard controller FSM; encodings are visible on the debug State port.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOADUSE  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FREEZE   = 2'd3
  } hz_state_e;

  // EX operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // One in-flight writer as seen from decode.
  typedef struct packed {
    logic                  valid;
    logic [CORE_REG_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_EMPTY = '{
    valid:    1'b0,
    rd:       '0,
    regwrite: 1'b0,
    memread:  1'b0
  };

  // A writer only matters if it really writes a register other than x0.
  function automatic logic entryLive(input shadow_entry_t e);
    return e.valid && e.regwrite && (e.rd != '0);
  endfunction

  // True when the entry is a live writer of register r.
  function automatic logic entryWrites(input shadow_entry_t e,
                                       input logic [CORE_REG_W-1:0] r);
    return entryLive(e) && (e.rd == r);
  endfunction

  // The youngest producer wins: the instruction now in EX will be in MEM
  // when the decode instruction reaches EX, so it takes precedence.
  function automatic logic [1:0] fwdSelect(input logic useRs,
                                           input logic hitEx,
                                           input logic hitMem);
    if (!useRs)  return FWD_RF;
    if (hitEx)   return FWD_MEM;
    if (hitMem)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Three-entry shadow of the writers currently in EX, MEM and WB. It is
//   filled from decode-stage information only and shifts in lockstep with the
//   pipeline registers.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   i_freeze          hold all entries (data memory busy)
//   i_bubble          load an empty entry into EX instead of the decode entry
//   i_decEntry        writer description of the instruction leaving decode
//   i_rs1, i_rs2      source registers of the instruction in decode
//   o_rs1MatchEx/Mem  rs1 is written by the live writer in EX / MEM
//   o_rs2MatchEx/Mem  rs2 is written by the live writer in EX / MEM
//   o_exLiveLoad      the entry in EX is a live load
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int REG_W = CORE_REG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_freeze,
  input  logic             i_bubble,
  input  shadow_entry_t    i_decEntry,
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  output logic             o_rs1MatchEx,
  output logic             o_rs2MatchEx,
  output logic             o_rs1MatchMem,
  output logic             o_rs2MatchMem,
  output logic             o_exLiveLoad
);

  shadow_entry_t r_ex;
  shadow_entry_t r_mem;
  shadow_entry_t r_wb;

  logic [CORE_REG_W-1:0] w_rs1;
  logic [CORE_REG_W-1:0] w_rs2;
  logic                  w_unusedWb;

  assign w_rs1 = CORE_REG_W'(i_rs1);
  assign w_rs2 = CORE_REG_W'(i_rs2);

  // Shift the shadow along with the pipeline. A freeze holds everything;
  // a bubble replaces only the incoming EX entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex  <= SHADOW_EMPTY;
      r_mem <= SHADOW_EMPTY;
      r_wb  <= SHADOW_EMPTY;
    end else if (!i_freeze) begin
      r_ex  <= i_bubble ? SHADOW_EMPTY : i_decEntry;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  assign o_rs1MatchEx  = entryWrites(r_ex,  w_rs1);
  assign o_rs2MatchEx  = entryWrites(r_ex,  w_rs2);
  assign o_rs1MatchMem = entryWrites(r_mem, w_rs1);
  assign o_rs2MatchMem = entryWrites(r_mem, w_rs2);
  assign o_exLiveLoad  = entryLive(r_ex) && r_ex.memread;

  // The WB writer is tracked so the shadow mirrors the real pipeline, but the
  // register file is write-through, so nothing in decode needs to see it.
  assign w_unusedWb = ^r_wb;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard controller for the 5-stage RV32I core. Detects load-use hazards
//   against a shadow scoreboard, drives the stall/flush enables of the front
//   pipeline registers, produces EX forward selects registered alongside the
//   ID/EX register, and counts stall and redirect cycles.
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   Rs1D, Rs2D, RdD        register fields of the instruction in decode
//   UseRs1D, UseRs2D       decode instruction reads rs1 / rs2
//   RegWriteD, MemReadD    decode instruction writes the RF / is a load
//   PCSrcE                 EX resolved a taken branch or jump
//   MemBusyM               data memory not ready, freeze the pipeline
//   StallF/D/E/M           hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD, FlushE         clear IF/ID, bubble into ID/EX
//   ForwardAE, ForwardBE   EX operand selects (00 RF, 01 ResultW, 10 ALUResultM)
//   StallCnt, FlushCnt     saturating load-use stall / redirect counters
//   State                  current FSM state for debug
// -----------------------------------------------------------------------------
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_W = CORE_REG_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic             UseRs1D,
  input  logic             UseRs2D,
  input  logic [REG_W-1:0] RdD,
  input  logic             RegWriteD,
  input  logic             MemReadD,
  input  logic             PCSrcE,
  input  logic             MemBusyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [1:0]       State
);

  hz_state_e     r_state;
  hz_state_e     w_nextState;

  shadow_entry_t w_decEntry;

  logic w_rs1MatchEx;
  logic w_rs2MatchEx;
  logic w_rs1MatchMem;
  logic w_rs2MatchMem;
  logic w_exLiveLoad;
  logic w_loadUse;

  logic w_stallF;
  logic w_stallD;
  logic w_stallE;
  logic w_stallM;
  logic w_flushD;
  logic w_flushE;

  logic [1:0] r_fwdA;
  logic [1:0] r_fwdB;
  logic [1:0] w_fwdANext;
  logic [1:0] w_fwdBNext;

  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic             w_countStall;
  logic             w_countFlush;

  assign w_decEntry = '{
    valid:    1'b1,
    rd:       CORE_REG_W'(RdD),
    regwrite: RegWriteD,
    memread:  MemReadD
  };

  hazard_scoreboard #(
    .REG_W (REG_W)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .i_freeze      (MemBusyM),
    .i_bubble      (w_flushE),
    .i_decEntry    (w_decEntry),
    .i_rs1         (Rs1D),
    .i_rs2         (Rs2D),
    .o_rs1MatchEx  (w_rs1MatchEx),
    .o_rs2MatchEx  (w_rs2MatchEx),
    .o_rs1MatchMem (w_rs1MatchMem),
    .o_rs2MatchMem (w_rs2MatchMem),
    .o_exLiveLoad  (w_exLiveLoad)
  );

  // A load in EX cannot forward its data in time to a dependent decode
  // instruction; only operands that are actually read count.
  assign w_loadUse = w_exLiveLoad &&
                     ((UseRs1D && w_rs1MatchEx) || (UseRs2D && w_rs2MatchEx));

  // FSM state register; the state records which action the previous cycle took.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and pipeline control in strict priority order: reset, memory
  // freeze, redirect, load-use. A redirect discards the decode instruction,
  // so a load-use hazard on it is moot. During a freeze PCSrcE is held by the
  // frozen EX stage and gets acted on once the freeze lifts.
  always_comb begin
    w_nextState = ST_RUN;
    w_stallF    = 1'b0;
    w_stallD    = 1'b0;
    w_stallE    = 1'b0;
    w_stallM    = 1'b0;
    w_flushD    = 1'b0;
    w_flushE    = 1'b0;
    if (reset) begin
      w_nextState = ST_RUN;
    end else if (MemBusyM) begin
      w_nextState = ST_FREEZE;
      w_stallF    = 1'b1;
      w_stallD    = 1'b1;
      w_stallE    = 1'b1;
      w_stallM    = 1'b1;
    end else if (PCSrcE) begin
      w_nextState = ST_REDIRECT;
      w_flushD    = 1'b1;
      w_flushE    = 1'b1;
    end else if (w_loadUse) begin
      w_nextState = ST_LOADUSE;
      w_stallF    = 1'b1;
      w_stallD    = 1'b1;
      w_flushE    = 1'b1;
    end
  end

  assign w_fwdANext = fwdSelect(UseRs1D, w_rs1MatchEx, w_rs1MatchMem);
  assign w_fwdBNext = fwdSelect(UseRs2D, w_rs2MatchEx, w_rs2MatchMem);

  // Forward selects move with the ID/EX register: held on a freeze, cleared
  // when a bubble is inserted, otherwise loaded from the decode comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwdA <= FWD_RF;
      r_fwdB <= FWD_RF;
    end else if (!MemBusyM) begin
      if (w_flushE) begin
        r_fwdA <= FWD_RF;
        r_fwdB <= FWD_RF;
      end else begin
        r_fwdA <= w_fwdANext;
        r_fwdB <= w_fwdBNext;
      end
    end
  end

  assign w_countStall = w_loadUse && !PCSrcE && !MemBusyM;
  assign w_countFlush = PCSrcE && !MemBusyM;

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_countStall && (r_stallCnt != {CNT_W{1'b1}})) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
      if (w_countFlush && (r_flushCnt != {CNT_W{1'b1}})) begin
        r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
    end
  end

  assign StallF    = w_stallF;
  assign StallD    = w_stallD;
  assign StallE    = w_stallE;
  assign StallM    = w_stallM;
  assign FlushD    = w_flushD;
  assign FlushE    = w_flushE;
  assign ForwardAE = r_fwdA;
  assign ForwardBE = r_fwdB;
  assign StallCnt  = r_stallCnt;
  assign FlushCnt  = r_flushCnt;
  assign State     = r_state;

endmodule
